timed_main_memory: RTL and testbench

Word-organised main memory that sits directly downstream of the cache and serves its miss-fill and write-through traffic over a request/done handshake. Each access takes a fixed, parameterised latency, so cache stall and refill logic is exercised with realistic timing. The block is a drop-in backing store behind the cache's memory-side bus: r/w type, 10-bit byte address, 32-bit write bus, 32-bit read bus and done strobe.

---
 rtl/timed_main_memory_pkg.sv | 17 +
 rtl/mem_word_array.sv | 40 ++++
 rtl/timed_main_memory.sv | 95 +++++++++
 tb/tb_timed_main_memory.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/timed_main_memory_pkg.sv
// Shared constants and types for the timed main memory.
// Holds bus widths, r/w encodings and the FSM state type.
package mem_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x WIDTH word storage: sync write, registered read,
// reset loads word i with value i.
// Ports: clk, rst_n, we, re, idx, wdata, rdata.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(i);
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/timed_main_memory.sv
// Fixed-latency word memory behind the cache (req / mem_done).
// Ports: clk, rst_n, req, r_w_type, addr, write_data, read_data, mem_done, busy.
module timed_main_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              r_w_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_done,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;

    state_t state, state_n;

    logic [3:0]        cnt;
    logic              rw_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wd_q;
    logic              commit;
    logic              we;
    logic              re;

    // Byte offset is irrelevant for word accesses.
    logic unused_addr;
    assign unused_addr = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request capture and latency countdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            rw_q  <= RW_READ;
            idx_q <= '0;
            wd_q  <= '0;
        end else if (state == IDLE && req) begin
            cnt   <= 4'(LATENCY - 1);
            rw_q  <= r_w_type;
            idx_q <= addr[ADDR_W-1:2];
            wd_q  <= write_data;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req) state_n = WAIT;
            WAIT:    if (cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        mem_done = (state == DONE);
        commit   = (state == WAIT) && (cnt == '0);
        we       = commit && (rw_q == RW_WRITE);
        re       = commit && (rw_q == RW_READ);
    end

    mem_word_array #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .re    (re),
        .idx   (idx_q),
        .wdata (wd_q),
        .rdata (read_data)
    );

endmodule

// File: tb/tb_timed_main_memory.sv
// Scoreboard bench for timed_main_memory.
// Three instances share stimulus: LATENCY 4, 1 and 15.
module tb_timed_main_memory;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        r_w_type = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] write_data = '0;

    logic [31:0] rd0, rd1, rd15;
    logic        done0, done1, done15;
    logic        busy0, busy1, busy15;

    timed_main_memory u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .r_w_type(r_w_type),
        .addr(addr), .write_data(write_data),
        .read_data(rd0), .mem_done(done0), .busy(busy0)
    );

    timed_main_memory #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .r_w_type(r_w_type),
        .addr(addr), .write_data(write_data),
        .read_data(rd1), .mem_done(done1), .busy(busy1)
    );

    timed_main_memory #(.LATENCY(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .req(req), .r_w_type(r_w_type),
        .addr(addr), .write_data(write_data),
        .read_data(rd15), .mem_done(done15), .busy(busy15)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    logic [31:0] model [256];
    logic [31:0] last_rd;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_done = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) model[i] = 32'(i);
        last_rd = '0;
    endfunction

    // Completion monitor for the LATENCY=4 instance.
    always @(negedge clk) begin
        if (rst_n && done0) begin
            n_done++;
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e_mon = q.pop_front();
                check("read_data", rd0, e_mon.data);
                check("latency", 32'(cyc - e_mon.acc), 32'd4);
            end
        end
    end

    task automatic wait_accept(output int c);
        logic p;
        bit   ok;
        ok = 0;
        c  = cyc;
        p  = busy0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (busy0 && !p) begin
                ok = 1;
                c  = cyc;
            end
            p = busy0;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_exp(logic rw, logic [9:0] a,
                            logic [31:0] d, int c);
        exp_t e;
        if (rw == RW_READ) begin
            e.data  = model[a[9:2]];
            last_rd = e.data;
        end else begin
            model[a[9:2]] = d;
            e.data = last_rd;
        end
        e.acc = c;
        q.push_back(e);
    endtask

    task automatic issue(logic rw, logic [9:0] a, logic [31:0] d);
        int c;
        @(negedge clk);
        req        = 1'b1;
        r_w_type   = rw;
        addr       = a;
        write_data = d;
        wait_accept(c);
        req = 1'b0;
        check("no_done_at_accept", 32'(done0), 32'd0);
        push_exp(rw, a, d, c);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1 && !busy15 && q.size() == 0) ok = 1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int a1, a2, d0, l1, l15;
        logic [31:0] r1, r15;

        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_read_data", rd0, 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);

        // Plain read of word 5
        issue(RW_READ, 10'd20, 32'd0);
        wait_idle();

        // Write then read back
        issue(RW_WRITE, 10'd44, 32'h114514);
        wait_idle();
        issue(RW_READ, 10'd44, 32'd0);
        wait_idle();

        // Misaligned write hits the containing word
        issue(RW_WRITE, 10'd46, 32'h17);
        issue(RW_READ, 10'd44, 32'd0);
        wait_idle();

        // Back-to-back with req held; addr changes during WAIT
        @(negedge clk);
        req      = 1'b1;
        r_w_type = RW_READ;
        addr     = 10'd40;
        wait_accept(a1);
        push_exp(RW_READ, 10'd40, 32'd0, a1);
        @(negedge clk);
        addr = 10'd108;
        wait_accept(a2);
        req = 1'b0;
        push_exp(RW_READ, 10'd108, 32'd0, a2);
        check("b2b_period", 32'(a2 - a1), 32'd6);
        wait_idle();

        // Reset two cycles into a write aborts it
        @(negedge clk);
        req        = 1'b1;
        r_w_type   = RW_WRITE;
        addr       = 10'd84;
        write_data = 32'h810;
        wait_accept(a1);
        req = 1'b0;
        d0  = n_done;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_read_data", rd0, 32'd0);
        issue(RW_READ, 10'd84, 32'd0);
        wait_idle();

        // Latency sweep and top address
        @(negedge clk);
        req      = 1'b1;
        r_w_type = RW_READ;
        addr     = 10'h3FF;
        wait_accept(a1);
        req = 1'b0;
        push_exp(RW_READ, 10'h3FF, 32'd0, a1);
        l1  = -1;
        l15 = -1;
        r1  = '0;
        r15 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1 && l1 < 0) begin
                l1 = cyc - a1;
                r1 = rd1;
            end
            if (done15 && l15 < 0) begin
                l15 = cyc - a1;
                r15 = rd15;
            end
        end
        check("lat1", 32'(l1), 32'd1);
        check("lat15", 32'(l15), 32'd15);
        check("lat1_data", r1, 32'hFF);
        check("lat15_data", r15, 32'hFF);
        wait_idle();

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
